// File: rtl/ref_sched_pkg.sv
// Shared definitions for the reference scheduler: FSM encoding, default
// parameters and the clamped step helper used by the ramp datapath.
package ref_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } state_e;

  localparam int unsigned DEF_STEP     = 4;
  localparam int unsigned DEF_TICK_DIV = 50000;

  // Move cur toward tgt by at most step; lands exactly on tgt, never overshoots.
  function automatic logic [7:0] step_toward(input logic [7:0] cur,
                                             input logic [7:0] tgt,
                                             input logic [7:0] step);
    logic [7:0] diff;
    if (tgt > cur) begin
      diff = tgt - cur;
      return (diff > step) ? cur + step : tgt;
    end else begin
      diff = cur - tgt;
      return (diff > step) ? cur - step : tgt;
    end
  endfunction

endpackage

// File: rtl/ref_scheduler_if.sv
// Request/grant and servo-load signals of the reference scheduler.
interface ref_scheduler_if;

  logic       req_a;
  logic [7:0] ref_a;
  logic       req_b;
  logic [7:0] ref_b;
  logic       gnt_a;
  logic       gnt_b;
  logic       enviar;
  logic [7:0] ref_out;
  logic       busy;

  modport master (
    output req_a, ref_a, req_b, ref_b,
    input  gnt_a, gnt_b, enviar, ref_out, busy
  );

  modport slave (
    input  req_a, ref_a, req_b, ref_b,
    output gnt_a, gnt_b, enviar, ref_out, busy
  );

endinterface

// File: rtl/tick_gen.sv
// Free-running divider: tick is high for one cycle every TICK_DIV clocks.
module tick_gen
  import ref_sched_pkg::*;
#(
  parameter int unsigned TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(TICK_DIV - 1);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? 16'd0 : cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= 16'd0;
    else      cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/ref_scheduler.sv
// Two-requester reference scheduler: round-robin arbiter picks a target and
// the FSM ramps the servo reference toward it by at most STEP per tick.
module ref_scheduler
  import ref_sched_pkg::*;
#(
  parameter int unsigned STEP     = DEF_STEP,
  parameter int unsigned TICK_DIV = DEF_TICK_DIV
) (
  input  logic            clk,
  input  logic            rst,
  ref_scheduler_if.slave  bus
);

  localparam logic [7:0] STEP_B = 8'(STEP);

  logic tick;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  state_e     state_q, state_d;
  logic [7:0] cur_q, cur_d;
  logic [7:0] tgt_q, tgt_d;
  logic [7:0] ref_out_q, ref_out_d;
  logic       gnt_a_q, gnt_a_d;
  logic       gnt_b_q, gnt_b_d;
  logic       enviar_q, enviar_d;
  logic       prio_a_q, prio_a_d;
  logic       elig_a, elig_b;

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    tgt_d     = tgt_q;
    ref_out_d = ref_out_q;
    enviar_d  = 1'b0;
    prio_a_d  = prio_a_q;

    // A requester whose grant is still on the bus has already been served.
    elig_a  = bus.req_a & ~gnt_a_q;
    elig_b  = bus.req_b & ~gnt_b_q;
    gnt_a_d = elig_a & (~elig_b | prio_a_q);
    gnt_b_d = elig_b & ~gnt_a_d;

    if (gnt_a_d) begin
      tgt_d    = bus.ref_a;
      prio_a_d = 1'b0;
    end else if (gnt_b_d) begin
      tgt_d    = bus.ref_b;
      prio_a_d = 1'b1;
    end

    // A grant landing on the tick edge is stepped toward immediately.
    if (tick && (tgt_d != cur_q)) begin
      cur_d     = step_toward(cur_q, tgt_d, STEP_B);
      enviar_d  = 1'b1;
      ref_out_d = cur_d;
    end

    case (state_q)
      IDLE:    if (tgt_d != cur_d) state_d = RAMP;
      RAMP:    if (tgt_d == cur_d) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cur_q     <= 8'd0;
      tgt_q     <= 8'd0;
      ref_out_q <= 8'd0;
      gnt_a_q   <= 1'b0;
      gnt_b_q   <= 1'b0;
      enviar_q  <= 1'b0;
      prio_a_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      tgt_q     <= tgt_d;
      ref_out_q <= ref_out_d;
      gnt_a_q   <= gnt_a_d;
      gnt_b_q   <= gnt_b_d;
      enviar_q  <= enviar_d;
      prio_a_q  <= prio_a_d;
    end
  end

  assign bus.gnt_a   = gnt_a_q;
  assign bus.gnt_b   = gnt_b_q;
  assign bus.enviar  = enviar_q;
  assign bus.ref_out = ref_out_q;
  assign bus.busy    = (state_q == RAMP);

endmodule

// File: tb/tb_ref_scheduler.sv
// Directed bench for ref_scheduler: a behavioural model checked every cycle
// plus literal expectations for each scenario.
module tb_ref_scheduler;

  localparam int TD = 4;
  localparam int ST = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ref_scheduler_if bus ();
  ref_scheduler_if bus2 ();

  ref_scheduler #(.STEP(ST), .TICK_DIV(TD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  ref_scheduler #(.STEP(255), .TICK_DIV(TD)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit chk_en = 0;

  logic [7:0] envq[$];
  int         envc[$];
  logic [7:0] env2q[$];

  // Model state: current value, target, edges since reset, priority, served flags.
  int m_cur, m_tgt, m_k, m_ref_out;
  bit m_prio_a, m_srv_a, m_srv_b;
  bit e_gnt_a, e_gnt_b, e_env;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_cur = 0; m_tgt = 0; m_k = 0; m_ref_out = 0;
    m_prio_a = 1; m_srv_a = 0; m_srv_b = 0;
    e_gnt_a = 0; e_gnt_b = 0; e_env = 0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        model_reset();
      end else begin
        bit ca, cb, tick;
        int d, mag;
        if (!bus.req_a) m_srv_a = 0;
        if (!bus.req_b) m_srv_b = 0;
        ca = bus.req_a && !m_srv_a;
        cb = bus.req_b && !m_srv_b;
        e_gnt_a = ca && (!cb || m_prio_a);
        e_gnt_b = cb && !e_gnt_a;
        if (e_gnt_a) begin
          m_tgt = int'(bus.ref_a); m_srv_a = 1; m_prio_a = 0;
        end else if (e_gnt_b) begin
          m_tgt = int'(bus.ref_b); m_srv_b = 1; m_prio_a = 1;
        end
        tick = ((m_k % TD) == TD - 1);
        m_k++;
        e_env = 0;
        if (tick && m_tgt != m_cur) begin
          d   = m_tgt - m_cur;
          mag = (d < 0) ? -d : d;
          if (mag > ST) mag = ST;
          m_cur     = m_cur + ((d < 0) ? -mag : mag);
          m_ref_out = m_cur;
          e_env     = 1;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("cyc_gnt_a",   bus.gnt_a,   32'(e_gnt_a));
        chk("cyc_gnt_b",   bus.gnt_b,   32'(e_gnt_b));
        chk("cyc_enviar",  bus.enviar,  32'(e_env));
        chk("cyc_ref_out", bus.ref_out, 32'(m_ref_out));
        chk("cyc_busy",    bus.busy,    32'(m_cur != m_tgt));
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.enviar) begin
        envq.push_back(bus.ref_out);
        envc.push_back(cyc);
      end
      if (bus2.enviar) env2q.push_back(bus2.ref_out);
    end
  end

  task automatic req_one(input bit is_b, input logic [7:0] v, output int lat);
    @(negedge clk);
    if (is_b) begin bus.req_b = 1'b1; bus.ref_b = v; end
    else      begin bus.req_a = 1'b1; bus.ref_a = v; end
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (is_b ? bus.gnt_b : bus.gnt_a) begin
        lat = i;
        break;
      end
    end
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
  endtask

  task automatic req_both(input logic [7:0] va, input logic [7:0] vb,
                          output int la, output int lb);
    @(negedge clk);
    bus.req_a = 1'b1; bus.ref_a = va;
    bus.req_b = 1'b1; bus.ref_b = vb;
    la = -1; lb = -1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (bus.gnt_a && la < 0) begin la = i; bus.req_a = 1'b0; end
      if (bus.gnt_b && lb < 0) begin lb = i; bus.req_b = 1'b0; end
      if (la > 0 && lb > 0) break;
    end
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    bit ok;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!bus.busy) begin ok = 1; break; end
    end
    chk(nm, 32'(ok), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_seq(input string nm, input int n, input int e0, input int e1, input int e2);
    int e[3];
    e[0] = e0; e[1] = e1; e[2] = e2;
    chk({nm, "_count"}, envq.size(), n);
    for (int i = 0; i < n && i < envq.size(); i++)
      chk($sformatf("%s_val%0d", nm, i), 32'(envq[i]), e[i]);
    if (envq.size() >= 3) begin
      chk({nm, "_gap0"}, envc[1] - envc[0], TD);
      chk({nm, "_gap1"}, envc[2] - envc[1], TD);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int lat, la, lb;
    bit ok2;
    bus.req_a = 0; bus.req_b = 0; bus.ref_a = 0; bus.ref_b = 0;
    bus2.req_a = 0; bus2.req_b = 0; bus2.ref_a = 0; bus2.ref_b = 0;
    repeat (3) @(negedge clk);
    chk_en = 1;
    chk("rst_ref_out", bus.ref_out, 0);
    chk("rst_busy", bus.busy, 0);
    rst = 1'b1;

    // 0 -> 10: steps of 4 clamped at the target.
    envq.delete(); envc.delete();
    req_one(0, 8'd10, lat);
    chk("t1_gnt_latency", lat, 1);
    wait_idle("t1_idle");
    chk_seq("t1_env", 3, 4, 8, 10);

    // Retarget to the current value: grant only.
    envq.delete(); envc.delete();
    req_one(0, 8'd10, lat);
    chk("t4_gnt_latency", lat, 1);
    chk("t4_busy", bus.busy, 0);
    repeat (8) @(negedge clk);
    chk("t4_no_enviar", envq.size(), 0);

    // 10 -> 0 without underflow.
    envq.delete(); envc.delete();
    req_one(1, 8'd0, lat);
    chk("t3_gnt_latency", lat, 1);
    wait_idle("t3_idle");
    chk_seq("t3_env", 3, 6, 2, 0);

    // STEP=255 instance: one jump to 255.
    @(negedge clk);
    bus2.req_a = 1'b1; bus2.ref_a = 8'd255;
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (bus2.gnt_a) begin lat = i; break; end
    end
    bus2.req_a = 1'b0;
    chk("t6_gnt_latency", lat, 1);
    ok2 = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!bus2.busy) begin ok2 = 1; break; end
    end
    chk("t6_idle", 32'(ok2), 1);
    repeat (6) @(negedge clk);
    chk("t6_count", env2q.size(), 1);
    chk("t6_value", (env2q.size() > 0) ? 32'(env2q[0]) : 32'hFFFF_FFFF, 255);

    // Simultaneous requests after reset: A first, then round-robin keeps A next.
    do_reset();
    envq.delete(); envc.delete();
    req_both(8'd20, 8'd30, la, lb);
    chk("t2_first_a", la, 1);
    chk("t2_then_b", lb, 2);
    wait_idle("t2_idle");
    chk("t2_count", envq.size(), 8);
    chk("t2_last", (envq.size() > 0) ? 32'(envq[$]) : 32'hFFFF_FFFF, 30);
    chk("t2_ref_out", bus.ref_out, 30);
    req_both(8'd40, 8'd50, la, lb);
    chk("t2b_first_a", la, 1);
    chk("t2b_then_b", lb, 2);
    wait_idle("t2b_idle");
    chk("t2b_ref_out", bus.ref_out, 50);

    // Asynchronous reset mid-ramp, then ramp restarts from 0.
    do_reset();
    envq.delete(); envc.delete();
    req_one(0, 8'd40, lat);
    chk("t5_gnt_latency", lat, 1);
    ok2 = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (envq.size() >= 2) begin ok2 = 1; break; end
    end
    chk("t5_two_steps", 32'(ok2), 1);
    chk("t5_mid_value", bus.ref_out, 8);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("t5_async_gnt_a", bus.gnt_a, 0);
    chk("t5_async_gnt_b", bus.gnt_b, 0);
    chk("t5_async_enviar", bus.enviar, 0);
    chk("t5_async_ref_out", bus.ref_out, 0);
    chk("t5_async_busy", bus.busy, 0);
    @(negedge clk);
    rst = 1'b1;
    envq.delete(); envc.delete();
    req_one(0, 8'd12, lat);
    chk("t5_regnt_latency", lat, 1);
    wait_idle("t5_idle");
    chk_seq("t5_env", 3, 4, 8, 12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
